regfile_wb_ctrl: RTL and testbench
==================================

# regfile_wb_ctrl

Write-back controller that owns the write port of the 32×32 integer register file: it merges single-cycle ALU results with in-order load returns from the data-memory interface and drives `reg_wr`/`waddr`/`wdata`. It keeps a busy scoreboard of registers with outstanding loads so the decode stage can stall on RAW/WAW hazards. It sits between execute/memory and the register file's write port.

## Interface
- `LD_DEPTH`, 4: maximum outstanding loads; power of two, ≥2
- `clk` in 1: clock; all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `alu_valid` in 1: ALU result valid this cycle; always accepted
- `alu_rd` in 5: ALU destination register
- `alu_data` in 32: ALU result
- `ld_issue` in 1: load issued this cycle (one pulse per load)
- `ld_issue_rd` in 5: destination of issued load
- `ld_full` out 1: `LD_DEPTH` loads outstanding
- `ld_rvalid` in 1: load data returning (in issue order)
- `ld_rready` out 1: controller can accept return data
- `ld_rdata` in 32: returned load data
- `hz_rs1`, `hz_rs2`, `hz_rd` in 5 each: decode-stage register addresses to check
- `stall` out 1: any checked register is busy
- `fwd1_valid`, `fwd2_valid` out 1 each; `fwd1_data`, `fwd2_data` out 32 each: load-buffer forwarding (see Configuration)
- `reg_wr` out 1, `waddr` out 5, `wdata` out 32: register-file write port, registered
- `proto_err` out 1: sticky protocol-violation flag

## Operation
- Pending-load FIFO of `LD_DEPTH` destination addresses; push on `ld_issue` when not full; head pops when its return data commits to the write port.
- `ld_issue` while `ld_full`: ignored, `proto_err` set. `ld_rvalid & ld_rready` with FIFO empty: data dropped, `proto_err` set.
- Busy vector `busy[31:1]`; x0 never busy. `ld_issue` accepted with rd≠0 sets `busy[rd]`. Load commit clears `busy[head_rd]`. Same-cycle set and clear of same rd: set wins.
- `stall = busy[hz_rs1] | busy[hz_rs2] | busy[hz_rd]`, combinational. Decode must not issue a load to a busy rd; doing so is not detected.
- One-entry return buffer (rd, data). `ld_rready = ~buf_valid`.
- Write-port arbitration each cycle, ALU has priority:
  - `alu_valid`: write port ← ALU result. A load return handshaking the same cycle goes into the buffer.
  - Else, if `buf_valid`: write port ← buffer; buffer empties; FIFO pops.
  - Else, if load return handshakes: write port ← return directly, with rd taken from FIFO head; FIFO pops.
  - Else `reg_wr` ← 0.
- Any write with rd=0: `reg_wr` ← 0. Load to x0 still pops the FIFO. `waddr`/`wdata` hold their previous values when `reg_wr`=0.
- `rst`: FIFO, busy, buffer, `proto_err` cleared. Outputs reset to `reg_wr`=0, `waddr`=0, `wdata`=0, `ld_full`=0, `ld_rready`=1, `stall`=0, `fwd*`=0. Loads outstanding at reset are forgotten; later returns flag `proto_err`.

## Timing
- ALU result presented in cycle N → `reg_wr` high in N+1. The register file captures on the falling edge of N+1.
- Load return handshake in N with no ALU write → `reg_wr` in N+1. With an ALU write in N → earliest N+2, later if the ALU keeps writing.
- Busy bit clears at the same edge `reg_wr` rises for that load. `stall` drops in the write cycle.
- `ld_full` and `ld_rready` are registered-state functions with no combinational input paths. `stall` and `fwd*` are combinational from the `hz_*` inputs.
- A FIFO push and pop in the same cycle at full is allowed only for the pop; the push is rejected by the `ld_full` rule.

## Configuration
- `WB_LD_FWD_EN` defined: if `buf_valid`, `buf_rd`≠0 and `buf_rd`==`hz_rs1` (or `hz_rs2`), then `fwd1_valid`=1 (`fwd2_valid`=1) and `fwd1_data`=`buf_data` (`fwd2_data`=`buf_data`). That rs is then excluded from the `stall` term.
- Not defined: `fwd*_valid`=0 and `fwd*_data`=0 permanently. `stall` is as above, with no exclusion.

## Test plan
- ALU only: `alu_valid`, rd=5, data 0xDEADBEEF at N → `reg_wr`=1, `waddr`=5, `wdata`=0xDEADBEEF at N+1. rd=0 → `reg_wr`=0.
- Load: issue rd=7; `hz_rs1`=7 → `stall`=1. Return 0x1234 with no ALU → write x7=0x1234 next cycle; `stall` low in that cycle.
- Collision: ALU rd=3 and load return (rd=9, 0xAA) in the same cycle → x3 written at N+1, x9 at N+2. `ld_rready`=0 during N+1.
- Fill: 4 issues → `ld_full`=1. A fifth issue → `proto_err`=1 and FIFO count stays 4. Four returns commit in issue order.
- Reset mid-operation: 2 loads outstanding, pulse `rst` → `busy`=0 and `stall`=0. A subsequent return → `proto_err`=1 and no write.
- With `WB_LD_FWD_EN`: buffered load rd=9, 0xAA, `hz_rs2`=9 → `fwd2_valid`=1, `fwd2_data`=0xAA, `stall`=0. Without the macro: `stall`=1.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: register-file write-back arbiter for ALU results and in-order load returns, with a busy scoreboard; WB_LD_FWD_EN enables forwarding from the return buffer.
module regfile_wb_ctrl #(
  parameter int LD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  output logic        ld_full,
  input  logic        ld_rvalid,
  output logic        ld_rready,
  input  logic [31:0] ld_rdata,
  input  logic [4:0]  hz_rs1,
  input  logic [4:0]  hz_rs2,
  input  logic [4:0]  hz_rd,
  output logic        stall,
  output logic        fwd1_valid,
  output logic        fwd2_valid,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data,
  output logic        reg_wr,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        proto_err
);
  localparam int AW = $clog2(LD_DEPTH);
  logic [4:0]  fifo_q [LD_DEPTH];
  logic [4:0]  fifo_d [LD_DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [31:0] busy_q, busy_d;
  logic        buf_valid_q, buf_valid_d;
  logic [4:0]  buf_rd_q, buf_rd_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        reg_wr_q, reg_wr_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        proto_err_q, proto_err_d;
  logic        empty, hs, hs_ok, push, pop, wr;
  logic [4:0]  wa, head_rd;
  logic [31:0] wd;
  assign ld_full   = cnt_q == (AW+1)'(LD_DEPTH);
  assign ld_rready = ~buf_valid_q;
  assign reg_wr    = reg_wr_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign proto_err = proto_err_q;
  always_comb begin
    fifo_d      = fifo_q;
    head_d      = head_q;
    tail_d      = tail_q;
    busy_d      = busy_q;
    buf_valid_d = buf_valid_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    empty       = cnt_q == '0;
    head_rd     = fifo_q[head_q];
    hs          = ld_rvalid & ~buf_valid_q;
    hs_ok       = hs & ~empty;
    push        = ld_issue & ~ld_full;
    pop         = 1'b0;
    wr          = 1'b0;
    wa          = waddr_q;
    wd          = wdata_q;
    if (alu_valid) begin
      wr = 1'b1;
      wa = alu_rd;
      wd = alu_data;
      if (hs_ok) begin
        buf_valid_d = 1'b1;
        buf_rd_d    = head_rd;
        buf_data_d  = ld_rdata;
      end
    end else if (buf_valid_q) begin
      wr          = 1'b1;
      wa          = buf_rd_q;
      wd          = buf_data_q;
      buf_valid_d = 1'b0;
      pop         = 1'b1;
    end else if (hs_ok) begin
      wr  = 1'b1;
      wa  = head_rd;
      wd  = ld_rdata;
      pop = 1'b1;
    end
    reg_wr_d    = wr & (wa != 5'd0);
    waddr_d     = reg_wr_d ? wa : waddr_q;
    wdata_d     = reg_wr_d ? wd : wdata_q;
    proto_err_d = proto_err_q | (ld_issue & ld_full) | (hs & empty);
    if (pop) begin
      busy_d[head_rd] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    // set after clear so a same-cycle re-issue to the committing rd stays busy
    if (push) begin
      fifo_d[tail_q]      = ld_issue_rd;
      tail_d              = tail_q + 1'b1;
      busy_d[ld_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q      <= '{default: '0};
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
      reg_wr_q    <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      fifo_q      <= fifo_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      reg_wr_q    <= reg_wr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      proto_err_q <= proto_err_d;
    end
  end
`ifdef WB_LD_FWD_EN
  assign fwd1_valid = buf_valid_q & (buf_rd_q != 5'd0) & (buf_rd_q == hz_rs1);
  assign fwd2_valid = buf_valid_q & (buf_rd_q != 5'd0) & (buf_rd_q == hz_rs2);
  assign fwd1_data  = fwd1_valid ? buf_data_q : 32'd0;
  assign fwd2_data  = fwd2_valid ? buf_data_q : 32'd0;
`else
  assign fwd1_valid = 1'b0;
  assign fwd2_valid = 1'b0;
  assign fwd1_data  = 32'd0;
  assign fwd2_data  = 32'd0;
`endif
  assign stall = (busy_q[hz_rs1] & ~fwd1_valid) | (busy_q[hz_rs2] & ~fwd2_valid) | busy_q[hz_rd];
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: scoreboard bench for regfile_wb_ctrl; expected writes are queued by the stimulus and popped by a write-port monitor.
module tb_regfile_wb_ctrl;
  logic        clk = 1'b0;
  logic        rst, alu_valid, ld_issue, ld_rvalid;
  logic [4:0]  alu_rd, ld_issue_rd, hz_rs1, hz_rs2, hz_rd;
  logic [31:0] alu_data, ld_rdata;
  logic        ld_full, ld_rready, stall, fwd1_valid, fwd2_valid, reg_wr, proto_err;
  logic [31:0] fwd1_data, fwd2_data, wdata;
  logic [4:0]  waddr;
  logic [36:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.LD_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_full(ld_full),
    .ld_rvalid(ld_rvalid), .ld_rready(ld_rready), .ld_rdata(ld_rdata),
    .hz_rs1(hz_rs1), .hz_rs2(hz_rs2), .hz_rd(hz_rd), .stall(stall),
    .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata), .proto_err(proto_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; ld_issue = 0; ld_rvalid = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && reg_wr) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got x%0d=0x%08h expected no write", waddr, wdata);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("write", {27'd0, waddr}, {27'd0, e[36:32]});
        chk("wdata", wdata, e[31:0]);
      end
    end
  end

  initial begin
    rst = 1; idle();
    alu_rd = 0; alu_data = 0; ld_issue_rd = 0; ld_rdata = 0;
    hz_rs1 = 0; hz_rs2 = 0; hz_rd = 0;
    step(); step();
    rst = 0;
    chk("rst_reg_wr", {31'd0, reg_wr}, 0);
    chk("rst_waddr", {27'd0, waddr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ld_full", {31'd0, ld_full}, 0);
    chk("rst_ld_rready", {31'd0, ld_rready}, 1);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_proto_err", {31'd0, proto_err}, 0);
    chk("rst_fwd", {30'd0, fwd1_valid, fwd2_valid}, 0);

    // ALU writes, x0 suppressed
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; exp_q.push_back({5'd5, 32'hDEADBEEF});
    step();
    alu_rd = 0; alu_data = 32'h1;
    step(); idle();
    step();
    chk("x0_keeps_wdata", wdata, 32'hDEADBEEF);

    // single load
    ld_issue = 1; ld_issue_rd = 7;
    step(); idle();
    hz_rs1 = 7; #1;
    chk("load_stall", {31'd0, stall}, 1);
    ld_rvalid = 1; ld_rdata = 32'h1234; exp_q.push_back({5'd7, 32'h1234});
    step(); idle();
    chk("load_stall_drop", {31'd0, stall}, 0);
    hz_rs1 = 0;

    // ALU/load collision
    ld_issue = 1; ld_issue_rd = 9;
    step(); idle();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33; ld_rvalid = 1; ld_rdata = 32'hAA;
    exp_q.push_back({5'd3, 32'h33}); exp_q.push_back({5'd9, 32'hAA});
    step(); idle();
    chk("coll_rready", {31'd0, ld_rready}, 0);
    hz_rs2 = 9; #1;
`ifdef WB_LD_FWD_EN
    chk("fwd2_valid", {31'd0, fwd2_valid}, 1);
    chk("fwd2_data", fwd2_data, 32'hAA);
    chk("fwd_stall", {31'd0, stall}, 0);
`else
    chk("nofwd_stall", {31'd0, stall}, 1);
    chk("nofwd_fwd2", {31'd0, fwd2_valid}, 0);
`endif
    step();
    chk("coll_rready_back", {31'd0, ld_rready}, 1);
    chk("coll_stall_clear", {31'd0, stall}, 0);
    hz_rs2 = 0;

    // fill to depth, overflow
    for (int i = 0; i < 4; i++) begin
      ld_issue = 1; ld_issue_rd = 5'(10 + i);
      step();
    end
    idle();
    chk("full", {31'd0, ld_full}, 1);
    chk("full_no_err", {31'd0, proto_err}, 0);
    ld_issue = 1; ld_issue_rd = 14;
    step(); idle();
    chk("overflow_err", {31'd0, proto_err}, 1);
    chk("still_full", {31'd0, ld_full}, 1);
    hz_rd = 14; #1;
    chk("rejected_not_busy", {31'd0, stall}, 0);
    hz_rd = 13; #1;
    chk("last_busy", {31'd0, stall}, 1);
    hz_rd = 0;
    for (int i = 0; i < 4; i++) begin
      ld_rvalid = 1; ld_rdata = 32'h100 + i; exp_q.push_back({5'(10 + i), 32'h100 + i});
      step();
    end
    idle();
    chk("drained", {31'd0, ld_full}, 0);

    // reset with loads outstanding
    ld_issue = 1; ld_issue_rd = 20; step();
    ld_issue_rd = 21; step(); idle();
    hz_rs1 = 20; hz_rs2 = 21; #1;
    chk("pre_rst_stall", {31'd0, stall}, 1);
    rst = 1; step(); rst = 0;
    chk("post_rst_stall", {31'd0, stall}, 0);
    chk("post_rst_err", {31'd0, proto_err}, 0);
    ld_rvalid = 1; ld_rdata = 32'h55;
    step(); idle();
    chk("orphan_err", {31'd0, proto_err}, 1);
    step(); step();
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
